// File: rtl/sram_ctrl_if.sv
// Request/response bus between the SoC peripheral decode and sram_ctrl.
interface sram_ctrl_if;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic        mem_error;
    logic [31:0] mem_rdata;

    modport master (
        output mem_valid, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_error, mem_rdata
    );

    modport slave (
        input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_error, mem_rdata
    );
endinterface

// File: rtl/sram_ctrl.sv
// 32-bit bus to 16-bit asynchronous SRAM bridge. Each access is split into a
// low and a high halfword phase of wait_states+1 cycles; write phases whose
// strobes are all clear are skipped.
module sram_ctrl #(
    parameter int unsigned wait_states = 2,
    parameter int unsigned addr_width  = 19
) (
    input  logic                  clock,
    input  logic                  reset,
    sram_ctrl_if.slave            ram,
    output logic [addr_width-1:0] sram_addr,
    output logic [15:0]           sram_dq_out,
    output logic                  sram_dq_oe,
    input  logic [15:0]           sram_dq_in,
    output logic                  sram_ce_n,
    output logic                  sram_oe_n,
    output logic                  sram_we_n,
    output logic                  sram_lb_n,
    output logic                  sram_ub_n
);
    typedef enum logic [1:0] {IDLE, LO, HI, RESP} state_t;

    localparam logic [3:0] WLAST = 4'(wait_states);

    state_t                state_q, state_d;
    logic [3:0]            wcnt_q, wcnt_d;
    logic [addr_width-2:0] base_q, base_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [31:0]           rdata_q, rdata_d;
    logic [3:0]            wstrb_q, wstrb_d;
    logic                  write_q, write_d;
    logic                  err_q, err_d;
    logic [addr_width-1:0] sram_addr_q, sram_addr_d;

    logic accept, range_err, in_phase, last;

    assign accept    = (state_q == IDLE) && ram.mem_valid;
    assign range_err = |ram.mem_addr[31:addr_width+1];
    assign in_phase  = (state_q == LO) || (state_q == HI);
    assign last      = (wcnt_q == WLAST);
    assign sram_addr = sram_addr_q;

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state: skip the low phase for upper-only writes, the high phase for lower-only writes
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (ram.mem_valid) begin
                if (range_err)                                     state_d = RESP;
                else if ((|ram.mem_wstrb) && ~|ram.mem_wstrb[1:0]) state_d = HI;
                else                                               state_d = LO;
            end
            LO:   if (last) state_d = (write_q && ~|wstrb_q[3:2]) ? RESP : HI;
            HI:   if (last) state_d = RESP;
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next-state: request latch, wait counter, read capture, pad address
    always_comb begin
        wcnt_d      = (in_phase && !last) ? wcnt_q + 4'd1 : 4'd0;
        base_d      = base_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        write_d     = write_q;
        err_d       = err_q;
        rdata_d     = rdata_q;
        sram_addr_d = sram_addr_q;
        if (accept) begin
            base_d  = ram.mem_addr[addr_width:2];
            wdata_d = ram.mem_wdata;
            wstrb_d = ram.mem_wstrb;
            write_d = |ram.mem_wstrb;
            err_d   = range_err;
            rdata_d = '0;
        end
        if (last && !write_q && state_q == LO) rdata_d[15:0]  = sram_dq_in;
        if (last && !write_q && state_q == HI) rdata_d[31:16] = sram_dq_in;
        // The pad address only moves on phase entry, so it holds between accesses
        if (state_d == LO && state_q != LO) sram_addr_d = {base_d, 1'b0};
        if (state_d == HI && state_q != HI) sram_addr_d = {base_d, 1'b1};
    end

    // Datapath registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wcnt_q      <= '0;
            base_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            write_q     <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
            sram_addr_q <= '0;
        end else begin
            wcnt_q      <= wcnt_d;
            base_q      <= base_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            write_q     <= write_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            sram_addr_q <= sram_addr_d;
        end
    end

    // Outputs: SRAM strobes during phases (we_n held off in the first cycle for address setup), bus response in RESP
    always_comb begin
        sram_ce_n     = 1'b1;
        sram_oe_n     = 1'b1;
        sram_we_n     = 1'b1;
        sram_lb_n     = 1'b1;
        sram_ub_n     = 1'b1;
        sram_dq_oe    = 1'b0;
        sram_dq_out   = '0;
        ram.mem_ready = 1'b0;
        ram.mem_error = 1'b0;
        ram.mem_rdata = '0;
        if (in_phase) begin
            sram_ce_n = 1'b0;
            if (write_q) begin
                sram_dq_oe = 1'b1;
                sram_we_n  = (wcnt_q == 4'd0);
                if (state_q == LO) begin
                    sram_dq_out = wdata_q[15:0];
                    sram_lb_n   = ~wstrb_q[0];
                    sram_ub_n   = ~wstrb_q[1];
                end else begin
                    sram_dq_out = wdata_q[31:16];
                    sram_lb_n   = ~wstrb_q[2];
                    sram_ub_n   = ~wstrb_q[3];
                end
            end else begin
                sram_oe_n = 1'b0;
                sram_lb_n = 1'b0;
                sram_ub_n = 1'b0;
            end
        end
        if (state_q == RESP) begin
            ram.mem_ready = 1'b1;
            ram.mem_error = err_q;
            ram.mem_rdata = (write_q || err_q) ? 32'h0 : rdata_q;
        end
    end
endmodule

// File: tb/tb_sram_ctrl.sv
// Randomized bench for sram_ctrl with a behavioural SRAM and a transaction-level
// reference: expected latency, response and strobe-cycle counts are derived
// from the access type alone, memory contents from a shadow halfword array.
module tb_sram_ctrl;
    localparam int W = 2;

    logic        clock = 1'b0;
    logic        rst_n = 1'b0;
    logic [18:0] sram_addr;
    logic [15:0] sram_dq_out, sram_dq_in;
    logic        sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n;

    sram_ctrl_if bus ();

    sram_ctrl #(.wait_states(W), .addr_width(19)) dut (
        .clock      (clock),
        .reset      (rst_n),
        .ram        (bus),
        .sram_addr  (sram_addr),
        .sram_dq_out(sram_dq_out),
        .sram_dq_oe (sram_dq_oe),
        .sram_dq_in (sram_dq_in),
        .sram_ce_n  (sram_ce_n),
        .sram_oe_n  (sram_oe_n),
        .sram_we_n  (sram_we_n),
        .sram_lb_n  (sram_lb_n),
        .sram_ub_n  (sram_ub_n)
    );

    always #5 clock = ~clock;

    // Behavioural SRAM (256 halfwords) with a preload port
    logic [15:0] sram [256];
    logic        ld_en = 1'b0;
    logic [7:0]  ld_a  = '0;
    logic [15:0] ld_d  = '0;
    assign sram_dq_in = sram[sram_addr[7:0]];
    always @(posedge clock) begin
        if (ld_en) sram[ld_a] <= ld_d;
        else if (!sram_ce_n && !sram_we_n && sram_dq_oe) begin
            if (!sram_lb_n) sram[sram_addr[7:0]][7:0]  <= sram_dq_out[7:0];
            if (!sram_ub_n) sram[sram_addr[7:0]][15:8] <= sram_dq_out[15:8];
        end
    end

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    logic [15:0] shadow [256];
    int          n_chk = 0, n_fail = 0;
    int          exp_cyc = -1;
    logic        exp_err = 1'b0;
    logic [31:0] exp_rdata = '0;
    logic [17:0] cur_hw = '0;
    int          n_ce = 0, n_oe = 0, n_we = 0, n_dq = 0;
    bit          junk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: sample on the falling edge, compare against the model, drive after it
    task automatic tick();
        @(negedge clock);
        if (rst_n) begin
            if (cyc == exp_cyc) begin
                chk("ready", 32'(bus.mem_ready), 32'd1);
                chk("error", 32'(bus.mem_error), 32'(exp_err));
                chk("rdata", bus.mem_rdata, exp_rdata);
            end else begin
                chk("quiet", {bus.mem_rdata[29:0], bus.mem_ready, bus.mem_error}, 32'd0);
            end
            if (!sram_ce_n) chk("sram_hw_base", 32'(sram_addr[18:1]), 32'(cur_hw));
        end
        if (!sram_ce_n) n_ce++;
        if (!sram_oe_n) n_oe++;
        if (!sram_we_n) n_we++;
        if (sram_dq_oe) n_dq++;
        #2;
    endtask

    task automatic txn(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                       output logic [31:0] mdl_rd);
        logic err, wr, lo, hi;
        int   p, lat, i0, i1, ce0, oe0, we0, dq0;
        err = |a[31:20];
        wr  = |ws;
        lo  = !wr || (|ws[1:0]);
        hi  = !wr || (|ws[3:2]);
        p   = err ? 0 : (int'(lo) + int'(hi));
        lat = err ? 1 : p * (W + 1) + 1;
        i0  = int'({a[8:2], 1'b0});
        i1  = i0 + 1;
        mdl_rd = (err || wr) ? 32'h0 : {shadow[i1], shadow[i0]};
        if (!err && wr) begin
            if (ws[0]) shadow[i0][7:0]  = wd[7:0];
            if (ws[1]) shadow[i0][15:8] = wd[15:8];
            if (ws[2]) shadow[i1][7:0]  = wd[23:16];
            if (ws[3]) shadow[i1][15:8] = wd[31:24];
        end
        exp_err   = err;
        exp_rdata = mdl_rd;
        cur_hw    = a[19:2];
        ce0 = n_ce; oe0 = n_oe; we0 = n_we; dq0 = n_dq;
        bus.mem_valid = 1'b1;
        bus.mem_addr  = a;
        bus.mem_wdata = wd;
        bus.mem_wstrb = ws;
        exp_cyc = cyc + lat;
        tick();
        bus.mem_valid = 1'b0;
        while (cyc < exp_cyc) begin
            bus.mem_valid = junk_en ? 1'($urandom) : 1'b0;
            bus.mem_addr  = $urandom;
            bus.mem_wdata = $urandom;
            bus.mem_wstrb = 4'($urandom);
            tick();
        end
        bus.mem_valid = 1'b0;
        tick();
        exp_cyc = -1;
        chk("ce_cycles", 32'(n_ce - ce0), 32'(p * (W + 1)));
        chk("oe_cycles", 32'(n_oe - oe0), wr ? 32'd0 : 32'(p * (W + 1)));
        chk("we_cycles", 32'(n_we - we0), wr ? 32'(p * W) : 32'd0);
        chk("dqoe_cycles", 32'(n_dq - dq0), wr ? 32'(p * (W + 1)) : 32'd0);
    endtask

    task automatic chk_idle_pins(input string tag);
        chk({tag, "_strobes"}, {27'd0, sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n}, 32'h1F);
        chk({tag, "_dq_oe"}, 32'(sram_dq_oe), 32'd0);
        chk({tag, "_sram_addr"}, 32'(sram_addr), 32'd0);
        chk({tag, "_resp"}, {bus.mem_rdata[29:0], bus.mem_ready, bus.mem_error}, 32'd0);
    endtask

    initial begin
        logic [31:0] rd, a, wd;
        logic [3:0]  ws;
        bus.mem_valid = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_wstrb = '0;

        // Preload SRAM and shadow while reset is held
        for (int i = 0; i < 256; i++) begin
            ld_en = 1'b1;
            ld_a  = 8'(i);
            ld_d  = (i == 8) ? 16'hBEEF : (i == 9) ? 16'hDEAD : (i == 5) ? 16'h3C3C : 16'($urandom);
            shadow[i] = ld_d;
            @(posedge clock);
            #1;
        end
        ld_en = 1'b0;
        chk_idle_pins("reset");
        @(negedge clock);
        #2;
        rst_n = 1'b1;

        // Directed cases with hand-computed expectations
        txn(32'h0000_0010, 32'h0, 4'h0, rd);
        chk("read_model", rd, 32'hDEADBEEF);
        txn(32'h0000_0004, 32'h1234_5678, 4'hF, rd);
        chk("write_model_rdata", rd, 32'h0);
        chk("hw2", 32'(sram[2]), 32'h5678);
        chk("hw3", 32'(sram[3]), 32'h1234);
        txn(32'h0000_0008, 32'h00AA_0000, 4'h4, rd);
        chk("hw5_lane", 32'(sram[5]), 32'h3CAA);
        txn(32'h0010_0000, 32'h0, 4'h0, rd);
        chk("err_model_rdata", rd, 32'h0);

        // Abort a write in the first LO cycle with reset
        bus.mem_valid = 1'b1;
        bus.mem_addr  = 32'h0000_0040;
        bus.mem_wdata = 32'hCAFE_F00D;
        bus.mem_wstrb = 4'hF;
        cur_hw = 18'h10;
        tick();
        bus.mem_valid = 1'b0;
        chk("abort_ce_active", 32'(sram_ce_n), 32'd0);
        rst_n = 1'b0;
        #1;
        chk_idle_pins("abort");
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        txn(32'h0000_0040, 32'h0, 4'h0, rd);
        chk("abort_no_write", 32'(sram[32]), 32'(shadow[32]));

        // Randomized traffic with ignored request pulses while busy
        junk_en = 1'b1;
        for (int n = 0; n < 300; n++) begin
            a  = 32'($urandom_range(0, 511));
            if ($urandom_range(0, 7) == 0) a = $urandom | 32'h0010_0000;
            ws = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
            wd = $urandom;
            txn(a, wd, ws, rd);
        end

        // Final memory image against the shadow
        for (int i = 0; i < 256; i += 17) chk("mem_image", 32'(sram[i]), 32'(shadow[i]));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/sram_ctrl.md
SRAM_CTRL -- requirements
Module: sram_ctrl

Interface
REQ-001 Parameter wait_states, default 2, extra cycles per 16-bit phase (legal 1..15); each phase lasts wait_states+1 cycles.
REQ-002 Parameter addr_width, default 19, external halfword address width (2^addr_width halfwords = 1 MiB).
REQ-003 clock  input  1  single clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 ram_in  input  mem_in_type  request from the soc peripheral decode; uses mem_valid, mem_addr (byte address, base already removed), mem_wdata[31:0], mem_wstrb[3:0].
REQ-006 ram_out  output  mem_out_type  response; mem_ready, mem_error, mem_rdata[31:0].
REQ-007 sram_addr  output  addr_width  external halfword address.
REQ-008 sram_dq_out  output  16  write data; sram_dq_oe  output  1  data bus drive enable.
REQ-009 sram_dq_in  input  16  read data from pads.
REQ-010 sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n  output  1 each  active-low chip, output, write and byte-lane enables.

Function
REQ-011 FSM states IDLE, LO, HI, RESP; 4-bit wait counter wcnt.
REQ-012 IDLE: mem_valid=1 sampled on edge k latches addr, wdata, wstrb; write = |wstrb; mem_valid in any other state is ignored and never answered.
REQ-013 Range check at accept: any of mem_addr[31:addr_width+1] set -> go to RESP with error flag, no external cycle.
REQ-014 Read, or write with |wstrb[1:0]: IDLE->LO; write with wstrb[1:0]=0: IDLE->HI directly.
REQ-015 LO exit: after wait_states+1 cycles, -> HI unless write with wstrb[3:2]=0, then -> RESP.
REQ-016 HI exit: after wait_states+1 cycles -> RESP; RESP -> IDLE after exactly one cycle.
REQ-017 sram_addr = {latched addr[addr_width:2], 0} in LO, {.., 1} in HI; mem_addr[1:0] ignored.
REQ-018 In LO/HI: sram_ce_n=0; read: sram_oe_n=0, lb_n=ub_n=0, dq_oe=0; write: sram_oe_n=1, dq_oe=1, dq_out = wdata[15:0] (LO) / wdata[31:16] (HI), lb_n/ub_n = ~wstrb lane bits of that half.
REQ-019 Write strobe: sram_we_n=0 from the 2nd cycle through the last cycle of each write phase; 1 in 1st cycle for address setup.
REQ-020 Read capture: sram_dq_in registered on the last cycle of LO into rdata[15:0], of HI into rdata[31:16].
REQ-021 Outside LO/HI: ce_n=oe_n=we_n=lb_n=ub_n=1, dq_oe=0, sram_addr holds last value.
REQ-022 RESP: mem_ready=1 for one cycle; mem_rdata = captured data for reads, 0 for writes/errors; mem_error=1 only for range error.
REQ-023 Latency (W=wait_states, accept edge k): full read/write ready in cycle k+2W+3; single-half write ready in cycle k+W+2; range error ready in cycle k+1.
REQ-024 mem_ready, mem_error, mem_rdata are 0 in every non-RESP cycle.
REQ-025 wcnt counts 0..W within a phase, resets to 0 on every phase entry; no wrap beyond W.

Reset
REQ-026 reset=0 asynchronously forces IDLE, wcnt=0, rdata=0, all ram_out fields 0, all SRAM strobes 1, dq_oe=0, sram_addr=0, including mid-phase; an aborted request is never answered.
REQ-027 First request is accepted on the first rising edge with reset=1 and mem_valid=1.

Verification
REQ-028 W=2, read addr 0x0000_0010, SRAM holds hw8=0xBEEF, hw9=0xDEAD -> sram_addr 8 then 9, oe_n low 3 cycles each, mem_rdata=0xDEADBEEF, ready in cycle k+7, error=0.
REQ-029 W=2, write addr 0x4, wdata 0x12345678, wstrb 0xF -> hw2=0x5678, hw3=0x1234, we_n low 2 cycles per phase, ready k+7, rdata=0.
REQ-030 Write wstrb 0x4, wdata 0x00AA0000, addr 0x8 -> only HI phase at hw5, lb_n=0, ub_n=1, dq_out=0x00AA, ready k+4.
REQ-031 Read addr 0x0010_0000 (addr_width=19) -> no ce_n activity, ready=1 error=1 rdata=0 in cycle k+1.
REQ-032 Drop reset during LO of a write -> strobes go high same cycle, no mem_ready; next request after release completes normally.
REQ-033 mem_valid pulsed during HI of a read -> ignored; exactly one mem_ready observed.
